// File: rtl/ycr1_div_arb.sv
// ycr1_div_arb: two-requester front end for a shared 32-bit divider.
// Picks one command (round-robin or fixed priority), encodes the operands,
// runs one divider transaction, returns the quotient or remainder to the
// owner, and supports cancelling the in-flight command.
module ycr1_div_arb #(
    parameter int FAIR = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  req_vld,
    input  logic [3:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [1:0]  req_rdy,
    input  logic [1:0]  req_kill,
    output logic [1:0]  rsp_vld,
    output logic [31:0] rsp_data,
    input  logic [1:0]  rsp_rdy,
    output logic        div_valid,
    output logic [32:0] div_din1,
    output logic [32:0] div_din2,
    input  logic [31:0] div_quot,
    input  logic [31:0] div_rem,
    input  logic        div_rdy,
    output logic        div_done
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DONE} state_t;

    state_t      state;
    logic        id;         // owner of the in-flight command
    logic        last;       // requester served most recently
    logic        kill_flag;  // owner cancelled before the result arrived
    logic [1:0]  op;

    logic        gnt_id;
    logic [1:0]  sel_op;
    logic [31:0] sel_a;
    logic [31:0] sel_b;
    logic        sel_signed;
    logic        own_kill;

    // Grant selection; the accept handshake is only offered in IDLE.
    always_comb begin
        gnt_id = 1'b0;
        if (req_vld == 2'b10)
            gnt_id = 1'b1;
        else if (req_vld == 2'b11 && FAIR != 0)
            gnt_id = ~last;
        req_rdy = 2'b00;
        if (rstn && state == IDLE && req_vld != 2'b00)
            req_rdy = gnt_id ? 2'b10 : 2'b01;
    end

    // Operand mux for the granted requester and kill of the current owner.
    always_comb begin
        sel_op     = gnt_id ? req_op[3:2]  : req_op[1:0];
        sel_a      = gnt_id ? req_a[63:32] : req_a[31:0];
        sel_b      = gnt_id ? req_b[63:32] : req_b[31:0];
        sel_signed = ~sel_op[0];
        own_kill   = id ? req_kill[1] : req_kill[0];
    end

    // Transaction FSM with registered strobes, response and operands.
    // Operands are only reloaded on the next accept, so they stay put
    // through div_done and the cycle after it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            id        <= 1'b0;
            last      <= 1'b1;
            kill_flag <= 1'b0;
            op        <= 2'b00;
            div_valid <= 1'b0;
            div_done  <= 1'b0;
            div_din1  <= '0;
            div_din2  <= '0;
            rsp_vld   <= 2'b00;
            rsp_data  <= '0;
        end else begin
            div_valid <= 1'b0;
            div_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_rdy != 2'b00) begin
                        id        <= gnt_id;
                        last      <= gnt_id;
                        op        <= sel_op;
                        kill_flag <= 1'b0;
                        div_din1  <= {sel_signed & sel_a[31], sel_a};
                        div_din2  <= {sel_signed & sel_b[31], sel_b};
                        div_valid <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (own_kill)
                        kill_flag <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    if (div_rdy) begin
                        if (kill_flag || own_kill) begin
                            div_done <= 1'b1;
                            state    <= DONE;
                        end else begin
                            rsp_data <= op[1] ? div_rem : div_quot;
                            rsp_vld  <= id ? 2'b10 : 2'b01;
                            state    <= RESP;
                        end
                    end else if (own_kill) begin
                        kill_flag <= 1'b1;
                    end
                end
                RESP: begin
                    if (own_kill || (rsp_vld & rsp_rdy) != 2'b00) begin
                        rsp_vld  <= 2'b00;
                        div_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
